// File: rtl/decoder_pkg.sv
// Shared types for the sequential one-hot decoder.
//   mode_e  : operation requested with each accepted address
//   state_e : controller states
//   max2    : helper used to size the shared dwell/pulse timer
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_PULSE = 2'b01,
    MODE_SCAN  = 2'b10,
    MODE_OFF   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    PULSE,
    SCAN
  } state_e;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/decoder_nbit_seq_if.sv
// Address/mode request channel of the sequential decoder.
//   a       : address or scan start index (N bits)
//   mode    : requested operation, qualified by a_valid
//   a_valid : requester has a valid a/mode this cycle
//   a_ready : decoder can take a request this cycle
// master = requesting control block, slave = decoder.
interface decoder_nbit_seq_if #(
  parameter int N = 4
);
  import decoder_pkg::*;

  logic [N-1:0] a;
  mode_e        mode;
  logic         a_valid;
  logic         a_ready;

  modport master (output a, output mode, output a_valid, input a_ready);
  modport slave  (input a, input mode, input a_valid, output a_ready);

endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter with a terminal-count flag.
//   clk, rst : clock and synchronous active-high reset
//   clear    : force the count to zero (idle)
//   load     : load load_val this cycle (wins over counting)
//   load_val : value to load, i.e. number of cycles until tc
//   tc       : high during the last cycle of a loaded interval
// After a load of L, tc is high in the L-th cycle following the load edge,
// so the owner acting on tc at the next edge gets an interval of exactly L.
module dwell_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == W'(1));

endmodule

// File: rtl/decoder_nbit_seq.sv
// Registered N-to-2^N one-hot decoder with hold, timed pulse and auto-scan.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, overrides everything
//   enable : global enable; low clears the output and returns to IDLE
//   bus    : request channel (a, mode, a_valid in; a_ready out)
//   y      : registered one-hot (or all-zero) output, 2^N bits
//   busy   : high while in PULSE or SCAN
//   wrap   : one-cycle flag when a scan steps from index 2^N-1 to 0
module decoder_nbit_seq
  import decoder_pkg::*;
#(
  parameter int N         = 4,
  parameter int DWELL     = 2,
  parameter int PULSE_LEN = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  decoder_nbit_seq_if.slave      bus,
  output logic [(2**N)-1:0]      y,
  output logic                   busy,
  output logic                   wrap
);

  localparam int W       = 2 ** N;
  localparam int CNT_MAX = max2(DWELL, PULSE_LEN);
  localparam int TW_RAW  = $clog2(CNT_MAX + 1);
  localparam int TW      = (TW_RAW < 1) ? 1 : TW_RAW;

  state_e         state_reg, state_next;
  logic [W-1:0]   y_reg, y_next;
  logic [N-1:0]   index_reg, index_next;
  logic           wrap_reg, wrap_next;
  logic           busy_reg;

  logic           accept;
  logic           tmr_clear, tmr_load, tmr_tc;
  logic [TW-1:0]  tmr_val;
  logic [N-1:0]   index_step;
  logic [W-1:0]   onehot_a, onehot_step;

  // A pulse in flight cannot be interrupted by a new request.
  assign bus.a_ready = enable && (state_reg != PULSE);
  assign accept      = bus.a_valid && bus.a_ready;

  // Natural N-bit rollover gives the modulo-2^N scan step.
  assign index_step = index_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_onehot
      assign onehot_a[gi]    = (bus.a == N'(gi));
      assign onehot_step[gi] = (index_step == N'(gi));
    end
  endgenerate

  dwell_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // State register, plus the registered outputs that move with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      y_reg     <= '0;
      index_reg <= '0;
      wrap_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      index_reg <= index_next;
      wrap_reg  <= wrap_next;
      busy_reg  <= (state_next == PULSE) || (state_next == SCAN);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = IDLE;
    end else if (accept) begin
      unique case (bus.mode)
        MODE_HOLD:  state_next = HOLD;
        MODE_PULSE: state_next = PULSE;
        MODE_SCAN:  state_next = SCAN;
        default:    state_next = IDLE;
      endcase
    end else if ((state_reg == PULSE) && tmr_tc) begin
      state_next = IDLE;
    end
  end

  // Output/datapath logic: next output word, scan index, wrap and timer control.
  always_comb begin
    y_next     = y_reg;
    index_next = index_reg;
    wrap_next  = 1'b0;
    tmr_clear  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    if (!enable) begin
      y_next    = '0;
      tmr_clear = 1'b1;
    end else if (accept) begin
      unique case (bus.mode)
        MODE_HOLD: begin
          y_next    = onehot_a;
          tmr_clear = 1'b1;
        end
        MODE_PULSE: begin
          y_next   = onehot_a;
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_LEN);
        end
        MODE_SCAN: begin
          // A new request restarts the scan with a full dwell interval.
          index_next = bus.a;
          y_next     = onehot_a;
          tmr_load   = 1'b1;
          tmr_val    = TW'(DWELL);
        end
        default: begin
          y_next    = '0;
          tmr_clear = 1'b1;
        end
      endcase
    end else if ((state_reg == PULSE) && tmr_tc) begin
      y_next = '0;
    end else if ((state_reg == SCAN) && tmr_tc) begin
      index_next = index_step;
      y_next     = onehot_step;
      wrap_next  = (index_reg == '1);
      tmr_load   = 1'b1;
      tmr_val    = TW'(DWELL);
    end
  end

  assign y    = y_reg;
  assign busy = busy_reg;
  assign wrap = wrap_reg;

  a_y_onehot0 : assert property (@(posedge clk) $onehot0(y_reg));

endmodule

// File: tb/tb_decoder_nbit_seq.sv
// Directed bench for decoder_nbit_seq (N=4, DWELL=2, PULSE_LEN=3), followed
// by a random run that checks the output never becomes multi-hot.
module tb_decoder_nbit_seq;
  import decoder_pkg::*;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] y;
  logic        busy;
  logic        wrap;

  int n_cmp;
  int n_err;

  decoder_nbit_seq_if #(.N(N)) bus ();

  decoder_nbit_seq #(.N(N), .DWELL(2), .PULSE_LEN(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .bus    (bus.slave),
    .y      (y),
    .busy   (busy),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] addr, input mode_e m);
    bus.a       = addr;
    bus.mode    = m;
    bus.a_valid = 1'b1;
  endtask

  logic [15:0] exp_y;

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    enable      = 1'b1;
    bus.a       = '0;
    bus.mode    = MODE_HOLD;
    bus.a_valid = 1'b0;

    // 1. reset
    tick();
    tick();
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.a_ready), 32'h1);
    tick();
    chk("idle_y", 32'(y), 32'h0);

    // 2. HOLD sweep, back-to-back accepts
    for (int i = 0; i < 16; i++) begin
      req(4'(i), MODE_HOLD);
      #1;
      chk("hold_ready", 32'(bus.a_ready), 32'h1);
      tick();
      exp_y = 16'h0001 << i;
      chk("hold_y", 32'(y), 32'(exp_y));
    end
    chk("hold_busy", 32'(busy), 32'h0);
    bus.a_valid = 1'b0;

    // 3. PULSE a=5; a request kept valid during the pulse must be ignored
    req(4'd5, MODE_PULSE);
    tick();
    chk("pulse_y1", 32'(y), 32'h0020);
    chk("pulse_busy", 32'(busy), 32'h1);
    chk("pulse_ready", 32'(bus.a_ready), 32'h0);
    req(4'd9, MODE_HOLD);
    tick();
    chk("pulse_y2", 32'(y), 32'h0020);
    chk("pulse_ready2", 32'(bus.a_ready), 32'h0);
    tick();
    chk("pulse_y3", 32'(y), 32'h0020);
    tick();
    chk("pulse_end_y", 32'(y), 32'h0);
    chk("pulse_end_busy", 32'(busy), 32'h0);
    chk("pulse_end_ready", 32'(bus.a_ready), 32'h1);
    bus.a_valid = 1'b0;
    tick();
    chk("pulse_after_y", 32'(y), 32'h0);

    // OFF after HOLD
    req(4'd7, MODE_HOLD);
    tick();
    chk("hold7_y", 32'(y), 32'h0080);
    req(4'd7, MODE_OFF);
    tick();
    chk("off_y", 32'(y), 32'h0);
    bus.a_valid = 1'b0;

    // 4. SCAN from 14 with wrap
    req(4'd14, MODE_SCAN);
    tick();
    bus.a_valid = 1'b0;
    chk("scan_y0", 32'(y), 32'h4000);
    chk("scan_busy", 32'(busy), 32'h1);
    chk("scan_wrap0", 32'(wrap), 32'h0);
    tick();
    chk("scan_y1", 32'(y), 32'h4000);
    tick();
    chk("scan_y2", 32'(y), 32'h8000);
    chk("scan_wrap2", 32'(wrap), 32'h0);
    tick();
    chk("scan_y3", 32'(y), 32'h8000);
    tick();
    chk("scan_y4", 32'(y), 32'h0001);
    chk("scan_wrap4", 32'(wrap), 32'h1);
    tick();
    chk("scan_y5", 32'(y), 32'h0001);
    chk("scan_wrap5", 32'(wrap), 32'h0);
    tick();
    chk("scan_y6", 32'(y), 32'h0002);
    // restart at a=3 with a fresh dwell interval
    req(4'd3, MODE_SCAN);
    tick();
    bus.a_valid = 1'b0;
    chk("rescan_y0", 32'(y), 32'h0008);
    tick();
    chk("rescan_y1", 32'(y), 32'h0008);
    tick();
    chk("rescan_y2", 32'(y), 32'h0010);

    // 5. enable dropped mid-scan
    enable = 1'b0;
    tick();
    chk("en0_y", 32'(y), 32'h0);
    chk("en0_busy", 32'(busy), 32'h0);
    chk("en0_ready", 32'(bus.a_ready), 32'h0);
    enable = 1'b1;
    tick();
    tick();
    chk("en1_y", 32'(y), 32'h0);
    chk("en1_busy", 32'(busy), 32'h0);
    chk("en1_ready", 32'(bus.a_ready), 32'h1);

    // 6. reset mid-pulse
    req(4'd2, MODE_PULSE);
    tick();
    bus.a_valid = 1'b0;
    chk("rp_y0", 32'(y), 32'h0004);
    tick();
    chk("rp_y1", 32'(y), 32'h0004);
    rst = 1'b1;
    tick();
    chk("rp_rst_y", 32'(y), 32'h0);
    chk("rp_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    #1;
    chk("rp_ready", 32'(bus.a_ready), 32'h1);
    tick();
    chk("rp_after_y", 32'(y), 32'h0);

    // Random mode/a/enable traffic; output must stay one-hot or zero.
    for (int c = 0; c < 2000; c++) begin
      enable      = ($urandom_range(0, 9) != 0);
      rst         = ($urandom_range(0, 99) == 0);
      bus.a_valid = ($urandom_range(0, 3) == 0);
      bus.a       = 4'($urandom_range(0, 15));
      bus.mode    = mode_e'($urandom_range(0, 3));
      tick();
      chk("rand_onehot0", 32'($onehot0(y)), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
